wb_trace_checker: RTL and testbench

Synthesizable writeback checker for the pipelined ARM core. It taps the register-file write ports, including the second port used by long multiplication, and keeps a shadow register file. A timestamped-free writeback trace is buffered in a FIFO for a downstream consumer. When the program halts or times out, the block compares a configurable set of expected register values and reports pass/fail. It replaces ad-hoc end-of-simulation register checks and works in simulation and on FPGA.

---
 rtl/wbchk_pkg.sv | 21 ++
 rtl/wbchk_fifo.sv | 68 ++++++
 rtl/wb_trace_checker.sv | 142 ++++++++++++++
 tb/tb_wb_trace_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wbchk_pkg.sv
// Shared types for the writeback checker: FSM states, trace entry layout, saturating add.
// Trace entry field widths match the default top configuration (2 ports, 16 regs, 32-bit data).
package wbchk_pkg;
    localparam int TR_PORT_W = 1;
    localparam int TR_ADDR_W = 4;
    localparam int TR_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} wbState_t;

    typedef struct packed {
        logic [TR_PORT_W-1:0] port;
        logic [TR_ADDR_W-1:0] addr;
        logic [TR_DATA_W-1:0] data;
    } traceEntry_t;

    function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction
endpackage

// File: rtl/wbchk_fifo.sv
// Trace FIFO: up to NPUSH pushes per cycle packed in ascending lane order, one pop per cycle.
// A push is visible at the head one edge later; a cycle whose pushes do not all fit is dropped whole.
module wbchk_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 8,
    parameter int NPUSH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [NPUSH-1:0]   pushEn,
    input  logic [NPUSH*W-1:0] pushDat,
    output logic               dropped,
    output logic               headVld,
    input  logic               popRdy,
    output logic [W-1:0]       headDat
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count, nPush, space;
    logic [PTR_W-1:0] slot [NPUSH];
    logic             pop, accept;

    // Each enabled lane lands after the enabled lanes below it.
    always_comb begin
        nPush = '0;
        for (int p = 0; p < NPUSH; p++) begin
            slot[p] = wrPtr + nPush[PTR_W-1:0];
            nPush   = nPush + CNT_W'(pushEn[p]);
        end
    end

    assign headVld = (count != '0);
    assign headDat = mem[rdPtr];
    assign pop     = headVld && popRdy;
    assign space   = CNT_W'(DEPTH) - count + CNT_W'(pop);
    assign accept  = (nPush <= space);
    assign dropped = (nPush != '0) && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            if (accept)
                wrPtr <= wrPtr + nPush[PTR_W-1:0];
            count <= count + (accept ? nPush : CNT_W'(0)) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            for (int p = 0; p < NPUSH; p++)
                if (pushEn[p])
                    mem[slot[p]] <= pushDat[p*W +: W];
        end
    end
endmodule

// File: rtl/wb_trace_checker.sv
// Shadows register-file writes during RUN, traces them through a FIFO, checks NCHK expected values after halt/timeout.
// Trace head valid one edge after the write; trace drops whole cycles when full; checks take NCHK+1 edges to done.
module wb_trace_checker import wbchk_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 16,
    parameter int NPORTS     = 2,
    parameter int NCHK       = 4,
    parameter int TIMEOUT    = 2500,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(NREGS),
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS*AW-1:0] wa,
    input  logic [NPORTS*DATA_W-1:0] wd,
    input  logic [NCHK*AW-1:0]   chk_addr,
    input  logic [NCHK*DATA_W-1:0] chk_val,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [PW-1:0]        trace_port,
    output logic [AW-1:0]        trace_addr,
    output logic [DATA_W-1:0]    trace_data,
    output logic                 trace_overflow,
    output logic                 done,
    output logic                 pass,
    output logic [NCHK-1:0]      fail_mask,
    output logic                 timed_out,
    output logic [31:0]          cycle_count,
    output logic [31:0]          write_count
);
    localparam int CW = (NCHK > 1) ? $clog2(NCHK) : 1;

    wbState_t                state;
    logic [CW-1:0]           chkIdx;
    logic [DATA_W-1:0]       shadow [NREGS];
    logic [31:0]             nWr;
    logic                    runNow, startNow, fifoDropped, headVld;
    traceEntry_t [NPORTS-1:0] pushEnt;
    traceEntry_t             head;

    assign runNow   = (state == RUN);
    assign startNow = start && (state == IDLE || state == DONE);

    always_comb begin
        nWr = '0;
        for (int p = 0; p < NPORTS; p++) begin
            nWr          = nWr + 32'(we[p]);
            pushEnt[p].port = TR_PORT_W'(p);
            pushEnt[p].addr = TR_ADDR_W'(wa[p*AW +: AW]);
            pushEnt[p].data = TR_DATA_W'(wd[p*DATA_W +: DATA_W]);
        end
    end

    wbchk_fifo #(
        .W     ($bits(traceEntry_t)),
        .DEPTH (FIFO_DEPTH),
        .NPUSH (NPORTS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (startNow),
        .pushEn  (we & {NPORTS{runNow}}),
        .pushDat (pushEnt),
        .dropped (fifoDropped),
        .headVld (headVld),
        .popRdy  (trace_ready),
        .headDat (head)
    );

    // Head fields are masked so stale RAM contents never reach the outputs.
    assign trace_valid = headVld;
    assign trace_port  = headVld ? PW'(head.port) : '0;
    assign trace_addr  = headVld ? AW'(head.addr) : '0;
    assign trace_data  = headVld ? DATA_W'(head.data) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            chkIdx         <= '0;
            cycle_count    <= '0;
            write_count    <= '0;
            fail_mask      <= '0;
            timed_out      <= 1'b0;
            trace_overflow <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            for (int r = 0; r < NREGS; r++)
                shadow[r] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (startNow) begin
                        state          <= RUN;
                        cycle_count    <= '0;
                        write_count    <= '0;
                        fail_mask      <= '0;
                        timed_out      <= 1'b0;
                        trace_overflow <= 1'b0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        for (int r = 0; r < NREGS; r++)
                            shadow[r] <= '0;
                    end else if (state == DONE) begin
                        done <= 1'b1;
                        pass <= (fail_mask == '0) && !timed_out;
                    end
                end
                RUN: begin
                    cycle_count <= satAdd(cycle_count, 32'd1);
                    write_count <= satAdd(write_count, nWr);
                    // Later ports overwrite earlier ones on an address collision.
                    for (int p = 0; p < NPORTS; p++)
                        if (we[p])
                            shadow[wa[p*AW +: AW]] <= wd[p*DATA_W +: DATA_W];
                    if (fifoDropped)
                        trace_overflow <= 1'b1;
                    if (halt) begin
                        state  <= CHECK;
                        chkIdx <= '0;
                    end else if (cycle_count == 32'(TIMEOUT - 1)) begin
                        state     <= CHECK;
                        chkIdx    <= '0;
                        timed_out <= 1'b1;
                    end
                end
                CHECK: begin
                    fail_mask[chkIdx] <= (shadow[chk_addr[chkIdx*AW +: AW]]
                                          != chk_val[chkIdx*DATA_W +: DATA_W]);
                    if (chkIdx == CW'(NCHK - 1))
                        state <= DONE;
                    else
                        chkIdx <= chkIdx + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker with TIMEOUT shortened to 20 RUN cycles.
module tb_wb_trace_checker;
    localparam int NCHK = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, halt, trace_ready;
    logic [1:0]   we;
    logic [7:0]   wa;
    logic [63:0]  wd;
    logic [15:0]  chk_addr;
    logic [127:0] chk_val;
    logic         trace_valid, trace_overflow, done, pass, timed_out;
    logic [0:0]   trace_port;
    logic [3:0]   trace_addr;
    logic [31:0]  trace_data;
    logic [3:0]   fail_mask;
    logic [31:0]  cycle_count, write_count;

    int checks = 0;
    int errors = 0;

    wb_trace_checker #(
        .DATA_W(32), .NREGS(16), .NPORTS(2), .NCHK(NCHK), .TIMEOUT(20), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .we(we), .wa(wa), .wd(wd), .chk_addr(chk_addr), .chk_val(chk_val),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_port(trace_port),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_overflow(trace_overflow),
        .done(done), .pass(pass), .fail_mask(fail_mask), .timed_out(timed_out),
        .cycle_count(cycle_count), .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic haltAndFinish();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (NCHK + 1) tick();
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, " trace_valid"}, trace_valid, 0);
        checkVal({tag, " trace_port"}, trace_port, 0);
        checkVal({tag, " trace_addr"}, trace_addr, 0);
        checkVal({tag, " trace_data"}, trace_data, 0);
        checkVal({tag, " overflow"}, trace_overflow, 0);
        checkVal({tag, " done"}, done, 0);
        checkVal({tag, " pass"}, pass, 0);
        checkVal({tag, " fail_mask"}, fail_mask, 0);
        checkVal({tag, " timed_out"}, timed_out, 0);
        checkVal({tag, " cycle_count"}, cycle_count, 0);
        checkVal({tag, " write_count"}, write_count, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; halt = 1'b0; trace_ready = 1'b0;
        we = '0; wa = '0; wd = '0;
        chk_addr = {4'd3, 4'd2, 4'd1, 4'd0};
        chk_val = '0;
        tick(); tick();
        checkAllZero("reset");
        reset = 1'b1;
        tick();

        // Single write then halt; done lands NCHK+1 edges after the halt edge.
        chk_val = {32'd0, 32'd0, 32'd0, 32'd10};
        pulseStart();
        we = 2'b01; wa = {4'd0, 4'd0}; wd = {32'd0, 32'd10};
        tick();
        we = '0;
        checkVal("t1 trace_valid", trace_valid, 1);
        checkVal("t1 trace_port", trace_port, 0);
        checkVal("t1 trace_addr", trace_addr, 0);
        checkVal("t1 trace_data", trace_data, 10);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (NCHK) tick();
        checkVal("t1 done early", done, 0);
        tick();
        checkVal("t1 done", done, 1);
        checkVal("t1 pass", pass, 1);
        checkVal("t1 fail_mask", fail_mask, 0);
        checkVal("t1 write_count", write_count, 1);
        checkVal("t1 cycle_count", cycle_count, 2);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        checkVal("t1 drained", trace_valid, 0);

        // Same-address dual write: port 1 wins, trace keeps port order.
        chk_val = {32'd0, 32'd7, 32'd0, 32'd0};
        pulseStart();
        checkVal("t2 done cleared", done, 0);
        checkVal("t2 pass cleared", pass, 0);
        we = 2'b11; wa = {4'd2, 4'd2}; wd = {32'd7, 32'd5};
        tick();
        we = '0;
        checkVal("t2 head0 port", trace_port, 0);
        checkVal("t2 head0 addr", trace_addr, 2);
        checkVal("t2 head0 data", trace_data, 5);
        halt = 1'b1; trace_ready = 1'b1;
        tick();
        halt = 1'b0; trace_ready = 1'b0;
        checkVal("t2 head1 valid", trace_valid, 1);
        checkVal("t2 head1 port", trace_port, 1);
        checkVal("t2 head1 data", trace_data, 7);
        repeat (NCHK + 1) tick();
        checkVal("t2 done", done, 1);
        checkVal("t2 pass", pass, 1);
        checkVal("t2 write_count", write_count, 2);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        checkVal("t2 drained", trace_valid, 0);

        // Timeout without halt.
        chk_val = '0;
        pulseStart();
        repeat (19) tick();
        checkVal("t3 timed_out at 19", timed_out, 0);
        checkVal("t3 cycle 19", cycle_count, 19);
        tick();
        checkVal("t3 timed_out at 20", timed_out, 1);
        checkVal("t3 cycle 20", cycle_count, 20);
        repeat (NCHK + 1) tick();
        checkVal("t3 done", done, 1);
        checkVal("t3 pass", pass, 0);
        checkVal("t3 fail_mask", fail_mask, 0);
        checkVal("t3 cycle held", cycle_count, 20);

        // Overflow: 5 cycles of dual writes into an 8-deep FIFO with no pops.
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            we = 2'b11;
            wa = {4'(5 + 2*i), 4'(4 + 2*i)};
            wd = {32'(32'h100 + 2*i + 1), 32'(32'h100 + 2*i)};
            tick();
            if (i == 3) checkVal("t4 no overflow yet", trace_overflow, 0);
        end
        we = '0;
        checkVal("t4 overflow", trace_overflow, 1);
        checkVal("t4 write_count", write_count, 10);
        haltAndFinish();
        checkVal("t4 done", done, 1);
        checkVal("t4 pass", pass, 1);
        checkVal("t4 overflow held", trace_overflow, 1);
        for (int k = 0; k < 8; k++) begin
            checkVal($sformatf("t4 e%0d valid", k), trace_valid, 1);
            checkVal($sformatf("t4 e%0d port", k), trace_port, k % 2);
            checkVal($sformatf("t4 e%0d addr", k), trace_addr, 4 + k);
            checkVal($sformatf("t4 e%0d data", k), trace_data, 32'h100 + k);
            trace_ready = 1'b1;
            tick();
        end
        trace_ready = 1'b0;
        checkVal("t4 drained", trace_valid, 0);

        // Mismatch on check 3.
        chk_val = {32'h1234, 32'd0, 32'd0, 32'd0};
        pulseStart();
        we = 2'b10; wa = {4'd3, 4'd0}; wd = {32'h1235, 32'd0};
        tick();
        we = '0;
        haltAndFinish();
        checkVal("t5 done", done, 1);
        checkVal("t5 fail_mask", fail_mask, 4'b1000);
        checkVal("t5 pass", pass, 0);
        checkVal("t5 timed_out", timed_out, 0);
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;

        // Asynchronous reset mid-RUN, then a clean restart.
        chk_val = '0;
        pulseStart();
        for (int i = 0; i < 7; i++) begin
            we = 2'b01; wa = {4'd0, 4'(i)}; wd = {32'd0, 32'(i + 1)};
            tick();
        end
        we = '0;
        checkVal("t6 write_count pre", write_count, 7);
        checkVal("t6 cycle_count pre", cycle_count, 7);
        checkVal("t6 trace_valid pre", trace_valid, 1);
        #2 reset = 1'b0;
        #1 checkAllZero("t6 async");
        tick();
        reset = 1'b1;
        tick();
        pulseStart();
        checkVal("t6 cycle restart", cycle_count, 0);
        checkVal("t6 write restart", write_count, 0);
        we = 2'b01; wa = {4'd0, 4'd5}; wd = {32'd0, 32'd9};
        tick();
        we = '0;
        checkVal("t6 write_count post", write_count, 1);
        checkVal("t6 cycle_count post", cycle_count, 1);
        haltAndFinish();
        checkVal("t6 done", done, 1);
        checkVal("t6 pass", pass, 1);
        checkVal("t6 fail_mask", fail_mask, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
